// File: rtl/mux_rr_arbiter_if.sv
// Handshake bundle between four requesters, the shared 4:1 mux arbiter and one consumer.
// slave = arbiter side, master = requester/consumer side.
interface mux_rr_arbiter_if #(
    parameter int WIDTH = 8
);
    logic [3:0]         req;
    logic [4*WIDTH-1:0] in_data;
    logic [3:0]         in_last;
    logic [3:0]         in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic               out_last;
    logic               out_ready;
    logic [1:0]         sel;
    logic               busy;

    modport slave (
        input  req, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, sel, busy
    );

    modport master (
        output req, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, sel, busy
    );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing a 4:1 data mux; each grant is held until its last beat transfers.
// Optional: define MUX_ARB_BURST_LIMIT_EN to also release a grant after BURST_MAX beats.
module mux_rr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int BURST_MAX = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    mux_rr_arbiter_if.slave bus
);
    typedef enum logic {IDLE, GRANT} state_e;

    if (BURST_MAX < 1 || BURST_MAX > 255) begin : g_bad_burst_max
        $error("BURST_MAX must be in 1..255");
    end

    state_e     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] pick_idx;
    logic       pick_found;
    logic [1:0] scan_idx;
    logic       xfer;
    logic       release_grant;
    logic       limit_hit;

    // Lowest priority goes to the lane just released: scan ptr, ptr+1, ... wrapping mod 4.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        pick_found = 1'b0;
        pick_idx   = ptr_q;
        scan_idx   = ptr_q;
        for (int i = 0; i < 4; i++) begin
            scan_idx = ptr_q + 2'(i);
            if (!pick_found && bus.req[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    // Datapath follows the registered select; req never reaches sel combinationally.
    always_comb begin
        bus.busy      = (state_q == GRANT);
        bus.sel       = sel_q;
        bus.out_valid = (state_q == GRANT) && bus.req[sel_q];
        bus.out_data  = bus.in_data[sel_q*WIDTH +: WIDTH];
        bus.out_last  = bus.in_last[sel_q];
        bus.in_ready  = 4'b0000;
        if (state_q == GRANT && bus.out_ready) begin
            bus.in_ready = 4'b0001 << sel_q;
        end
        xfer = bus.out_valid && bus.out_ready;
    end

`ifdef MUX_ARB_BURST_LIMIT_EN
    logic [7:0] beat_cnt_q, beat_cnt_d;

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        limit_hit  = xfer && ((beat_cnt_q + 8'd1) == 8'(BURST_MAX));
        if (state_q == IDLE) begin
            beat_cnt_d = 8'd0;
        end else if (xfer) begin
            beat_cnt_d = beat_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt_q <= 8'd0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end
`else
    always_comb begin
        limit_hit = 1'b0;
    end
`endif

    always_comb begin
        release_grant = xfer && (bus.in_last[sel_q] || limit_hit);
        state_d       = state_q;
        sel_d         = sel_q;
        ptr_d         = ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    sel_d   = pick_idx;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (release_grant) begin
                    ptr_d   = sel_q + 2'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is sampled synchronously.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
            ptr_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed self-checking bench for mux_rr_arbiter: reset, rotation, burst hold, stalls, req drop, reset mid-burst.
module tb_mux_rr_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mux_rr_arbiter_if #(.WIDTH(8)) bus ();

    mux_rr_arbiter #(.WIDTH(8), .BURST_MAX(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then sit 1ns after it so registered state has settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_grant(input string tag, input logic [1:0] s, input logic v, input logic [3:0] rdy);
        check({tag, ".busy"}, 32'(bus.busy), 32'd1);
        check({tag, ".sel"}, 32'(bus.sel), 32'(s));
        check({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
        check({tag, ".ready"}, 32'(bus.in_ready), 32'(rdy));
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".busy"}, 32'(bus.busy), 32'd0);
        check({tag, ".valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, ".ready"}, 32'(bus.in_ready), 32'd0);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.req       = 4'b1111;
        bus.in_last   = 4'b1111;
        bus.out_ready = 1'b1;
        bus.in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

        // Reset held with every lane requesting.
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle($sformatf("rst%0d", i));
            check($sformatf("rst%0d.sel", i), 32'(bus.sel), 32'd0);
        end

        // Round robin with single-beat bursts: 0,1,2,3,0 with one bubble between grants.
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            check_grant($sformatf("rr%0d", k), 2'(k % 4), 1'b1, 4'b0001 << (k % 4));
            check($sformatf("rr%0d.data", k), 32'(bus.out_data), 32'(8'hA0 + 8'(k % 4)));
            check($sformatf("rr%0d.last", k), 32'(bus.out_last), 32'd1);
            tick();
            check_idle($sformatf("rr%0d.bubble", k));
            if (k == 4) bus.req = 4'b0000;
            tick();
        end

        // Lane 2 burst of 4 beats with a 3-cycle stall on beat 2; lane 1 waits.
        check_idle("quiet");
        bus.req = 4'b0100;
        tick();
        bus.req = 4'b0110;
        bus.in_last = 4'b0000;
        bus.in_data[16 +: 8] = 8'h21;
        settle();
        check_grant("b2.beat1", 2'd2, 1'b1, 4'b0100);
        check("b2.beat1.data", 32'(bus.out_data), 32'h21);
        tick();
        bus.in_data[16 +: 8] = 8'h22;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check_grant($sformatf("b2.stall%0d", i), 2'd2, 1'b1, 4'b0000);
            check($sformatf("b2.stall%0d.data", i), 32'(bus.out_data), 32'h22);
            tick();
        end
        bus.out_ready = 1'b1;
        settle();
        check("b2.beat2.ready", 32'(bus.in_ready), 32'h4);
        tick();
        bus.in_data[16 +: 8] = 8'h23;
        settle();
        check_grant("b2.beat3", 2'd2, 1'b1, 4'b0100);
        check("b2.beat3.last", 32'(bus.out_last), 32'd0);
        tick();
        bus.in_data[16 +: 8] = 8'h24;
        bus.in_last = 4'b0100;
        settle();
        check_grant("b2.beat4", 2'd2, 1'b1, 4'b0100);
        check("b2.beat4.last", 32'(bus.out_last), 32'd1);
        tick();
        bus.req = 4'b0010;
        check_idle("b2.release");
        tick();
        check_grant("b1.grant", 2'd1, 1'b1, 4'b0010);

        // Lane 1 drops req for two cycles mid-burst while lane 3 requests.
        bus.req = 4'b1010;
        bus.in_last = 4'b0000;
        bus.in_data[8 +: 8] = 8'h31;
        settle();
        check("b1.beat1.data", 32'(bus.out_data), 32'h31);
        tick();
        bus.req = 4'b1000;
        for (int i = 0; i < 2; i++) begin
            settle();
            check_grant($sformatf("b1.drop%0d", i), 2'd1, 1'b0, 4'b0010);
            tick();
        end
        bus.req = 4'b1010;
        bus.in_last = 4'b0010;
        bus.in_data[8 +: 8] = 8'h32;
        settle();
        check_grant("b1.last", 2'd1, 1'b1, 4'b0010);
        check("b1.last.flag", 32'(bus.out_last), 32'd1);
        tick();
        bus.req = 4'b1000;
        check_idle("b1.release");
        tick();
        check_grant("b3.grant", 2'd3, 1'b1, 4'b1000);

        // Reset during beat 2 of a lane-3 burst; ptr=0 shows as lane 0 winning next.
        bus.in_last = 4'b0000;
        tick();
        bus.in_data[24 +: 8] = 8'h42;
        rst_n = 1'b0;
        tick();
        check_idle("midrst");
        check("midrst.sel", 32'(bus.sel), 32'd0);
        check("midrst.data", 32'(bus.out_data), 32'hA0);
        rst_n = 1'b1;
        bus.req = 4'b1111;
        tick();
        check_grant("postrst", 2'd0, 1'b1, 4'b0001);
        bus.in_last = 4'b1111;
        tick();
        bus.req = 4'b0001;
        bus.in_last = 4'b0000;
        tick();

        // Lane 0 five-beat burst with lane 1 requesting; BURST_MAX=3 on the instance.
        check_grant("lim.grant", 2'd0, 1'b1, 4'b0001);
        bus.req = 4'b0011;
        for (int b = 1; b <= 3; b++) begin
            bus.in_data[0 +: 8] = 8'(8'h50 + b);
            settle();
            check_grant($sformatf("lim.beat%0d", b), 2'd0, 1'b1, 4'b0001);
            check($sformatf("lim.beat%0d.last", b), 32'(bus.out_last), 32'd0);
            tick();
        end
`ifdef MUX_ARB_BURST_LIMIT_EN
        check_idle("lim.release");
        tick();
        check_grant("lim.b1", 2'd1, 1'b1, 4'b0010);
        bus.in_last = 4'b0010;
        tick();
        bus.req = 4'b0001;
        bus.in_last = 4'b0000;
        tick();
        check_grant("lim.resume", 2'd0, 1'b1, 4'b0001);
        bus.in_data[0 +: 8] = 8'h54;
        settle();
        check("lim.resume.data", 32'(bus.out_data), 32'h54);
        tick();
        bus.in_data[0 +: 8] = 8'h55;
        bus.in_last = 4'b0001;
        settle();
        check_grant("lim.beat5", 2'd0, 1'b1, 4'b0001);
        tick();
        check_idle("lim.done");
`else
        for (int b = 4; b <= 5; b++) begin
            bus.in_data[0 +: 8] = 8'(8'h50 + b);
            if (b == 5) bus.in_last = 4'b0001;
            settle();
            check_grant($sformatf("nolim.beat%0d", b), 2'd0, 1'b1, 4'b0001);
            check($sformatf("nolim.beat%0d.data", b), 32'(bus.out_data), 32'(8'h50 + b));
            tick();
        end
        bus.req = 4'b0010;
        check_idle("nolim.release");
        tick();
        check_grant("nolim.b1", 2'd1, 1'b1, 4'b0010);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
